// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes and command type for the fixed-point ALU
// and its command feeder.
package alu_pkg;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 10;
    localparam int INST_W = 4;

    localparam logic [INST_W-1:0] OP_ADD  = 4'd0;
    localparam logic [INST_W-1:0] OP_SUB  = 4'd1;
    localparam logic [INST_W-1:0] OP_MUL  = 4'd2;
    localparam logic [INST_W-1:0] OP_MAC  = 4'd3;
    localparam logic [INST_W-1:0] OP_GELU = 4'd4;
    localparam logic [INST_W-1:0] BUBBLE_INST = OP_ADD;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [INST_W-1:0] inst;
    } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_feeder_if.sv
// alu_cmd_feeder_if: command stream, ALU issue/status and result signals of
// the feeder; slave is the feeder side, master the surrounding logic.
interface alu_cmd_feeder_if #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int INST_W = alu_pkg::INST_W
);
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [DATA_W-1:0] i_cmd_a;
    logic [DATA_W-1:0] i_cmd_b;
    logic [INST_W-1:0] i_cmd_inst;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic [INST_W-1:0] o_alu_inst;
    logic              i_alu_busy;
    logic              i_alu_valid;
    logic [DATA_W-1:0] i_alu_data;
    logic              o_res_valid;
    logic [DATA_W-1:0] o_res_data;
    logic [INST_W-1:0] o_res_inst;
    logic [7:0]        o_bubble_cnt;

    modport master (
        output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_inst, i_alu_busy, i_alu_valid, i_alu_data,
        input  o_cmd_ready, o_alu_a, o_alu_b, o_alu_inst, o_res_valid, o_res_data, o_res_inst,
               o_bubble_cnt
    );
    modport slave (
        input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_inst, i_alu_busy, i_alu_valid, i_alu_data,
        output o_cmd_ready, o_alu_a, o_alu_b, o_alu_inst, o_res_valid, o_res_data, o_res_inst,
               o_bubble_cnt
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO with registered occupancy; push is ignored
// when full, pop when empty.
module alu_cmd_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_clk)
        if (do_push) mem[wr_ptr] <= din;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/alu_cmd_feeder.sv
// alu_cmd_feeder: buffers ALU commands, issues one per ALU busy-low slot and
// fills empty slots with an accumulator-preserving ADD bubble.
module alu_cmd_feeder #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int INST_W = alu_pkg::INST_W,
    parameter int DEPTH  = 4
) (
    input logic             i_clk,
    input logic             i_rst_n,
    alu_cmd_feeder_if.slave bus
);
    import alu_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [INST_W-1:0] inst;
    } cmd_t;

    cmd_t              head;
    logic              full;
    logic              empty;
    logic              issue;
    logic              issued;
    logic [INST_W-1:0] fl_inst;
    logic [DATA_W-1:0] last_data;

    assign issue           = !bus.i_alu_busy;
    assign bus.o_cmd_ready = !full;

    alu_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (bus.i_cmd_valid),
        .pop     (issue),
        .din     ({bus.i_cmd_a, bus.i_cmd_b, bus.i_cmd_inst}),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            bus.o_alu_a      <= '0;
            bus.o_alu_b      <= '0;
            bus.o_alu_inst   <= '0;
            bus.o_res_valid  <= 1'b0;
            bus.o_res_data   <= '0;
            bus.o_res_inst   <= '0;
            bus.o_bubble_cnt <= '0;
            issued           <= 1'b0;
            fl_inst          <= '0;
            last_data        <= '0;
        end else begin
            bus.o_res_valid <= 1'b0;
            if (bus.i_alu_valid) begin
                last_data <= bus.i_alu_data;
                issued    <= 1'b0;
                if (issued) begin
                    bus.o_res_valid <= 1'b1;
                    bus.o_res_data  <= bus.i_alu_data;
                    bus.o_res_inst  <= fl_inst;
                end
            end
            // A bubble adds zero to the last result, leaving the MAC accumulator untouched
            if (issue) begin
                bus.o_alu_a    <= empty ? last_data : head.a;
                bus.o_alu_b    <= empty ? '0 : head.b;
                bus.o_alu_inst <= empty ? INST_W'(BUBBLE_INST) : head.inst;
                issued         <= !empty;
                if (!empty) fl_inst <= head.inst;
                if (empty && bus.o_bubble_cnt != 8'hFF) bus.o_bubble_cnt <= bus.o_bubble_cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_alu_cmd_feeder.sv
// tb_alu_cmd_feeder: drives the feeder against a behavioural ALU stand-in and
// checks results in order through a scoreboard of expected {data, inst}.
module tb_alu_cmd_feeder;
    import alu_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [INST_W-1:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic slots_on = 1'b0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int slot_cyc = 0;
    int slot_n = 0;
    int res_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [DATA_W-1:0] mdl_acc = '0;
    logic [DATA_W-1:0] alu_acc = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_cmd_feeder_if bus ();

    alu_cmd_feeder #(.DATA_W(DATA_W), .INST_W(INST_W), .DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    function automatic logic [DATA_W-1:0] fx_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p;
        p = $signed(a) * $signed(b);
        return p[FRAC_W +: DATA_W];
    endfunction

    // Reference ALU; GELU is stood in by a ReLU since only routing is under test
    function automatic logic [DATA_W-1:0] ref_op(input logic [INST_W-1:0] i, input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] acc);
        case (i)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return fx_mul(a, b);
            OP_MAC:  return acc + fx_mul(a, b);
            OP_GELU: return a[DATA_W-1] ? '0 : a;
            default: return a ^ b;
        endcase
    endfunction

    function automatic alu_cmd_t mk(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                    input logic [INST_W-1:0] i);
        return {a, b, i};
    endfunction

    // ALU stand-in: busy low one cycle T, sample at T+2, valid at T+3/T+4/T+10
    initial begin
        logic [DATA_W-1:0] sa, sbv, r;
        logic [INST_W-1:0] si;
        int lat;
        logic ab;
        bus.i_alu_busy  = 1'b1;
        bus.i_alu_valid = 1'b0;
        bus.i_alu_data  = '0;
        r = '0;
        forever begin
            @(negedge clk);
            bus.i_alu_valid = 1'b0;
            if (!rst_n) begin alu_acc = '0; continue; end
            if (!slots_on) continue;
            bus.i_alu_busy = 1'b0;
            slot_cyc = cyc;
            slot_n++;
            @(negedge clk);
            bus.i_alu_busy = 1'b1;
            if (!rst_n) begin alu_acc = '0; continue; end
            sa  = bus.o_alu_a;
            sbv = bus.o_alu_b;
            si  = bus.o_alu_inst;
            lat = (si == OP_MAC) ? 4 : (si == OP_GELU) ? 10 : 3;
            ab  = 1'b0;
            for (int k = 2; k <= lat; k++) begin
                @(negedge clk);
                if (!rst_n) begin ab = 1'b1; break; end
                total++;
                if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_inst} !== {sa, sbv, si}) begin
                    bad++;
                    $display("FAIL alu_hold k=%0d got a=%h b=%h inst=%0d want a=%h b=%h inst=%0d",
                             k, bus.o_alu_a, bus.o_alu_b, bus.o_alu_inst, sa, sbv, si);
                end
                if (k == 2) begin
                    r = ref_op(si, sa, sbv, alu_acc);
                    if (si == OP_MAC) alu_acc = r;
                end
            end
            if (ab) begin alu_acc = '0; continue; end
            bus.i_alu_valid = 1'b1;
            bus.i_alu_data  = r;
            @(negedge clk);
            bus.i_alu_valid = 1'b0;
        end
    end

    always @(negedge clk)
        if (bus.o_res_valid) begin
            res_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL res_unexpected got data=%h inst=%0d want no strobe", bus.o_res_data, bus.o_res_inst);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.o_res_data, bus.o_res_inst} !== mon_e) begin
                    bad++;
                    $display("FAIL res_data got data=%h inst=%0d want data=%h inst=%0d",
                             bus.o_res_data, bus.o_res_inst, mon_e.data, mon_e.inst);
                end
            end
        end

    task automatic push_cmd(input alu_cmd_t c);
        int n;
        exp_t e;
        @(negedge clk);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_a     = c.a;
        bus.i_cmd_b     = c.b;
        bus.i_cmd_inst  = c.inst;
        n = 0;
        while (!bus.o_cmd_ready && n < 50) begin @(negedge clk); n++; end
        total++;
        if (!bus.o_cmd_ready) begin
            bad++;
            $display("FAIL push_timeout got ready=%b want 1", bus.o_cmd_ready);
        end else begin
            e.data = ref_op(c.inst, c.a, c.b, mdl_acc);
            e.inst = c.inst;
            if (c.inst == OP_MAC) mdl_acc = e.data;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 bus.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        slots_on = 1'b0;
        sb.delete();
        mdl_acc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_inst, bus.o_res_valid, bus.o_res_data, bus.o_res_inst,
             bus.o_bubble_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got a=%h b=%h inst=%0d rv=%b rd=%h ri=%0d bc=%0d want all 0",
                     bus.o_alu_a, bus.o_alu_b, bus.o_alu_inst, bus.o_res_valid, bus.o_res_data,
                     bus.o_res_inst, bus.o_bubble_cnt);
        end
        total++;
        if (bus.o_cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got %b want 1", bus.o_cmd_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        int n;
        do_reset();
        push_cmd(mk(16'h0400, 16'h0800, OP_ADD));
        slots_on = 1'b1;
        n = 0;
        while (bus.o_res_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        total++;
        if (bus.o_res_valid !== 1'b1 || cyc - slot_cyc != 4) begin
            bad++;
            $display("FAIL add_latency got rv=%b lat=%0d want rv=1 lat=4", bus.o_res_valid, cyc - slot_cyc);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int n;
        int acc_cyc;
        exp_t e;
        do_reset();
        push_cmd(mk(16'h0100, 16'h0200, OP_ADD));
        push_cmd(mk(16'h0100, 16'h0300, OP_SUB));
        push_cmd(mk(16'h0600, 16'h0A00, OP_MUL));
        push_cmd(mk(16'h1234, 16'h00FF, 4'd7));
        @(negedge clk);
        total++;
        if (bus.o_cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready got %b want 0", bus.o_cmd_ready);
        end
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_a     = 16'hAAAA;
        bus.i_cmd_b     = 16'h5555;
        bus.i_cmd_inst  = 4'd5;
        slots_on = 1'b1;
        n = 0;
        while (!bus.o_cmd_ready && n < 40) begin @(negedge clk); n++; end
        acc_cyc = cyc;
        total++;
        if (!bus.o_cmd_ready || acc_cyc != slot_cyc + 1) begin
            bad++;
            $display("FAIL fifth_accept got ready=%b cycle=%0d want ready=1 cycle=%0d",
                     bus.o_cmd_ready, acc_cyc, slot_cyc + 1);
        end else begin
            e.data = ref_op(4'd5, 16'hAAAA, 16'h5555, mdl_acc);
            e.inst = 4'd5;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 bus.i_cmd_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_mac_bubble();
        logic [7:0] b0;
        do_reset();
        push_cmd(mk(16'h0400, 16'h0800, OP_MAC));
        slots_on = 1'b1;
        wait_drain();
        b0 = bus.o_bubble_cnt;
        repeat (12) @(negedge clk);
        total++;
        if (!(bus.o_bubble_cnt > b0)) begin
            bad++;
            $display("FAIL bubble_inc got %0d want >%0d", bus.o_bubble_cnt, b0);
        end
        total++;
        if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_inst} !== {16'h0800, 16'h0000, OP_ADD}) begin
            bad++;
            $display("FAIL bubble_ops got a=%h b=%h inst=%0d want a=0800 b=0000 inst=0",
                     bus.o_alu_a, bus.o_alu_b, bus.o_alu_inst);
        end
        push_cmd(mk(16'h0400, 16'h0400, OP_MAC));
        wait_drain();
    endtask

    task automatic test_idle();
        int n;
        int s0;
        int r0;
        do_reset();
        r0 = res_cnt;
        s0 = slot_n;
        slots_on = 1'b1;
        n = 0;
        while (slot_n < s0 + 300 && n < 2500) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        total++;
        if (bus.o_bubble_cnt !== 8'hFF || slot_n < s0 + 300) begin
            bad++;
            $display("FAIL bubble_sat got cnt=%0d slots=%0d want cnt=255 slots>=300", bus.o_bubble_cnt, slot_n - s0);
        end
        total++;
        if (res_cnt != r0) begin
            bad++;
            $display("FAIL idle_strobes got %0d want 0", res_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        do_reset();
        r0 = res_cnt;
        push_cmd(mk(16'h0C00, 16'h0000, OP_GELU));
        push_cmd(mk(16'h0600, 16'h0A00, OP_MUL));
        push_cmd(mk(16'h0100, 16'h0300, OP_SUB));
        push_cmd(mk(16'hF800, 16'h0000, OP_GELU));
        slots_on = 1'b1;
        wait_drain();
        total++;
        if (res_cnt != r0 + 4) begin
            bad++;
            $display("FAIL mixed_count got %0d want 4", res_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_gelu();
        int n;
        int s0;
        int r0;
        do_reset();
        push_cmd(mk(16'h0C00, 16'h0000, OP_GELU));
        s0 = slot_n;
        slots_on = 1'b1;
        n = 0;
        while (slot_n == s0 && n < 50) begin @(negedge clk); n++; end
        while (cyc < slot_cyc + 3) @(negedge clk);
        rst_n = 1'b0;
        slots_on = 1'b0;
        sb.delete();
        mdl_acc = '0;
        r0 = res_cnt;
        #1;
        total++;
        if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_inst, bus.o_res_valid, bus.o_res_data, bus.o_res_inst,
             bus.o_bubble_cnt} !== '0 || bus.o_cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_outputs got a=%h b=%h inst=%0d rv=%b bc=%0d ready=%b want zeros ready=1",
                     bus.o_alu_a, bus.o_alu_b, bus.o_alu_inst, bus.o_res_valid, bus.o_bubble_cnt, bus.o_cmd_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (res_cnt != r0) begin
            bad++;
            $display("FAIL lost_cmd_strobe got %0d want 0", res_cnt - r0);
        end
        push_cmd(mk(16'h0300, 16'h0100, OP_ADD));
        slots_on = 1'b1;
        wait_drain();
        total++;
        if (res_cnt != r0 + 1) begin
            bad++;
            $display("FAIL post_reset_count got %0d want 1", res_cnt - r0);
        end
    endtask

    initial begin
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_a     = '0;
        bus.i_cmd_b     = '0;
        bus.i_cmd_inst  = '0;
        test_reset();
        test_single_add();
        test_backpressure();
        test_mac_bubble();
        test_idle();
        test_back_to_back();
        test_reset_mid_gelu();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
